// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS-subset core: FSM state codes, decoder
// instruction classes, ALU encodings and the controller's control word.
package cpu_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned ITYPE_W = 4;

  localparam logic [STATE_W-1:0] S_IDLE = 4'd0;
  localparam logic [STATE_W-1:0] S_IF   = 4'd1;
  localparam logic [STATE_W-1:0] S_ID   = 4'd2;
  localparam logic [STATE_W-1:0] S_EXR  = 4'd3;
  localparam logic [STATE_W-1:0] S_WBR  = 4'd4;
  localparam logic [STATE_W-1:0] S_EXI  = 4'd5;
  localparam logic [STATE_W-1:0] S_WBI  = 4'd6;
  localparam logic [STATE_W-1:0] S_BR   = 4'd7;
  localparam logic [STATE_W-1:0] S_ADDR = 4'd8;
  localparam logic [STATE_W-1:0] S_MEM  = 4'd9;
  localparam logic [STATE_W-1:0] S_WBM  = 4'd10;

  localparam logic [ITYPE_W-1:0] IT_UNSUP = 4'd0;
  localparam logic [ITYPE_W-1:0] IT_RTYPE = 4'd1;
  localparam logic [ITYPE_W-1:0] IT_IMM   = 4'd2;
  localparam logic [ITYPE_W-1:0] IT_BEQ   = 4'd3;
  localparam logic [ITYPE_W-1:0] IT_LW    = 4'd4;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;
  localparam logic [1:0] ALUOP_IMM   = 2'd3;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  // ir_write/pc_write are qualified by MemAck in the top; branch by Zero.
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       branch;
    logic       decode;
    logic       retire;
  } ctrl_word_t;

  function automatic logic itype_legal(input logic [ITYPE_W-1:0] it);
    return (it == IT_RTYPE) || (it == IT_IMM) || (it == IT_BEQ) || (it == IT_LW);
  endfunction

endpackage

// File: rtl/ctrl_outdec.sv
// Combinational decoder from the registered FSM state to the control word.
module ctrl_outdec
  import cpu_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  output ctrl_word_t         cw_c
);

  always_comb begin
    cw_c = '0;
    case (state)
      S_IF: begin
        cw_c.mem_req   = 1'b1;
        cw_c.ir_write  = 1'b1;
        cw_c.pc_write  = 1'b1;
        cw_c.alu_src_b = SRCB_FOUR;
        cw_c.alu_op    = ALUOP_ADD;
      end
      // Branch target is computed speculatively into ALUOut during decode.
      S_ID: begin
        cw_c.decode    = 1'b1;
        cw_c.alu_src_b = SRCB_IMM_SH;
        cw_c.alu_op    = ALUOP_ADD;
      end
      S_EXR: begin
        cw_c.alu_src_a = 1'b1;
        cw_c.alu_src_b = SRCB_RT;
        cw_c.alu_op    = ALUOP_FUNCT;
      end
      S_WBR: begin
        cw_c.reg_write = 1'b1;
        cw_c.reg_dst   = 1'b1;
        cw_c.retire    = 1'b1;
      end
      S_EXI: begin
        cw_c.alu_src_a = 1'b1;
        cw_c.alu_src_b = SRCB_IMM;
        cw_c.alu_op    = ALUOP_IMM;
      end
      S_WBI: begin
        cw_c.reg_write = 1'b1;
        cw_c.retire    = 1'b1;
      end
      S_BR: begin
        cw_c.alu_src_a = 1'b1;
        cw_c.alu_src_b = SRCB_RT;
        cw_c.alu_op    = ALUOP_SUB;
        cw_c.pc_src    = 1'b1;
        cw_c.branch    = 1'b1;
        cw_c.retire    = 1'b1;
      end
      S_ADDR: begin
        cw_c.alu_src_a = 1'b1;
        cw_c.alu_src_b = SRCB_IMM;
        cw_c.alu_op    = ALUOP_ADD;
      end
      S_MEM: begin
        cw_c.mem_req = 1'b1;
        cw_c.iord    = 1'b1;
      end
      S_WBM: begin
        cw_c.reg_write  = 1'b1;
        cw_c.mem_to_reg = 1'b1;
        cw_c.retire     = 1'b1;
      end
      default: cw_c = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle controller: state register, next-state logic, PC enable and
// retired-instruction counter around the ctrl_outdec control-word decoder.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Run,
  input  logic [ITYPE_W-1:0] InstrType,
  input  logic               Zero,
  input  logic               MemAck,
  output logic               MemReq,
  output logic               IorD,
  output logic               IRWrite,
  output logic               PCEn,
  output logic               PCSrc,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic               Illegal,
  output logic [CNT_W-1:0]   InstrCount,
  output logic [STATE_W-1:0] State
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  ctrl_word_t         cw_c;

  ctrl_outdec u_outdec (
    .state (state_q),
    .cw_c  (cw_c)
  );

  // Run is only consulted at instruction boundaries; in-flight work completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (Run) state_d = S_IF;
      S_IF:   if (MemAck) state_d = S_ID;
      S_ID: begin
        case (InstrType)
          IT_RTYPE: state_d = S_EXR;
          IT_IMM:   state_d = S_EXI;
          IT_BEQ:   state_d = S_BR;
          IT_LW:    state_d = S_ADDR;
          default:  state_d = Run ? S_IF : S_IDLE;
        endcase
      end
      S_EXR:  state_d = S_WBR;
      S_EXI:  state_d = S_WBI;
      S_ADDR: state_d = S_MEM;
      S_MEM:  if (MemAck) state_d = S_WBM;
      S_WBR, S_WBI, S_BR, S_WBM: state_d = Run ? S_IF : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cw_c.retire) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign MemReq     = cw_c.mem_req;
  assign IorD       = cw_c.iord;
  assign IRWrite    = cw_c.ir_write & MemAck;
  assign PCEn       = (cw_c.pc_write & MemAck) | (cw_c.branch & Zero);
  assign PCSrc      = cw_c.pc_src;
  assign RegWrite   = cw_c.reg_write;
  assign RegDst     = cw_c.reg_dst;
  assign MemtoReg   = cw_c.mem_to_reg;
  assign ALUSrcA    = cw_c.alu_src_a;
  assign ALUSrcB    = cw_c.alu_src_b;
  assign ALUOp      = cw_c.alu_op;
  assign Illegal    = cw_c.decode & ~itype_legal(InstrType);
  assign InstrCount = cnt_q;
  assign State      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: an instruction-level model emits the
// expected per-cycle phase sequence; a negedge monitor compares the DUT.
module tb_multicycle_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  // Phase values are the architectural state codes.
  typedef enum int {
    P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_ALU_R = 3, P_WB_R = 4,
    P_ALU_I = 5, P_WB_I = 6, P_BRANCH = 7, P_ADDR = 8, P_MEM = 9, P_WB_LW = 10
  } phase_e;

  typedef struct {
    logic [3:0]  st;
    logic [13:0] outs;
    int          cnt;
    int          cyc_no;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             Run, Zero, MemAck;
  logic [3:0]       InstrType;
  logic             MemReq, IorD, IRWrite, PCEn, PCSrc, RegWrite, RegDst, MemtoReg;
  logic             ALUSrcA, Illegal;
  logic [1:0]       ALUSrcB, ALUOp;
  logic [CNT_W-1:0] InstrCount;
  logic [3:0]       State;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;
  int   cyc_no   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Run(Run), .InstrType(InstrType), .Zero(Zero),
    .MemAck(MemAck), .MemReq(MemReq), .IorD(IorD), .IRWrite(IRWrite), .PCEn(PCEn),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .Illegal(Illegal),
    .InstrCount(InstrCount), .State(State)
  );

  function automatic logic rb();
    return 1'($urandom % 2);
  endfunction

  function automatic logic [3:0] rit();
    return 4'($urandom % 16);
  endfunction

  // {MemReq,IorD,IRWrite,PCEn,PCSrc,RegWrite,RegDst,MemtoReg,ALUSrcA,ALUSrcB,ALUOp,Illegal}
  function automatic logic [13:0] exp_out(input phase_e p, input logic ack, input logic zero,
                                          input logic [3:0] it);
    logic mreq, iord, irw, pcen, pcsrc, rw, rdst, m2r, sa, ill;
    logic [1:0] sb, op;
    {mreq, iord, irw, pcen, pcsrc, rw, rdst, m2r, sa, ill} = '0;
    sb = 2'd0;
    op = 2'd0;
    case (p)
      P_FETCH:  begin mreq = 1'b1; sb = 2'd1; irw = ack; pcen = ack; end
      P_DECODE: begin sb = 2'd3; ill = !(it >= 4'd1 && it <= 4'd4); end
      P_ALU_R:  begin sa = 1'b1; op = 2'd2; end
      P_WB_R:   begin rw = 1'b1; rdst = 1'b1; end
      P_ALU_I:  begin sa = 1'b1; sb = 2'd2; op = 2'd3; end
      P_WB_I:   begin rw = 1'b1; end
      P_BRANCH: begin sa = 1'b1; op = 2'd1; pcsrc = 1'b1; pcen = zero; end
      P_ADDR:   begin sa = 1'b1; sb = 2'd2; end
      P_MEM:    begin mreq = 1'b1; iord = 1'b1; end
      P_WB_LW:  begin rw = 1'b1; m2r = 1'b1; end
      default:  ;
    endcase
    return {mreq, iord, irw, pcen, pcsrc, rw, rdst, m2r, sa, sb, op, ill};
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show in that cycle.
  task automatic cyc(input phase_e p, input logic run, input logic ack, input logic zero,
                     input logic [3:0] it);
    exp_t e;
    Run = run; MemAck = ack; Zero = zero; InstrType = it;
    e.st = 4'(int'(p));
    e.outs = exp_out(p, ack, zero, it);
    e.cnt = exp_cnt;
    e.cyc_no = cyc_no;
    sbq.push_back(e);
    cyc_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic retire();
    exp_cnt = (exp_cnt + 1) % CNT_MOD;
  endtask

  // One instruction; run_end is the Run level at the cycle that decides IF vs IDLE.
  task automatic do_instr(input logic [3:0] it, input int fwait, input int mwait,
                          input logic zero, input logic run_end);
    for (int i = 0; i <= fwait; i++) cyc(P_FETCH, rb(), (i == fwait), rb(), rit());
    if (!(it >= 4'd1 && it <= 4'd4)) begin
      cyc(P_DECODE, run_end, rb(), rb(), it);
      return;
    end
    cyc(P_DECODE, rb(), rb(), rb(), it);
    case (it)
      4'd1: begin
        cyc(P_ALU_R, rb(), rb(), rb(), rit());
        cyc(P_WB_R, run_end, rb(), rb(), rit());
      end
      4'd2: begin
        cyc(P_ALU_I, rb(), rb(), rb(), rit());
        cyc(P_WB_I, run_end, rb(), rb(), rit());
      end
      4'd3: cyc(P_BRANCH, run_end, rb(), zero, rit());
      default: begin
        cyc(P_ADDR, rb(), rb(), rb(), rit());
        for (int j = 0; j <= mwait; j++) cyc(P_MEM, rb(), (j == mwait), rb(), rit());
        cyc(P_WB_LW, run_end, rb(), rb(), rit());
      end
    endcase
    retire();
  endtask

  // Idle with Run low (MemAck noise must be ignored), then raise Run for one IDLE cycle.
  task automatic resume(input int n);
    for (int i = 0; i < n; i++) cyc(P_IDLE, 1'b0, rb(), rb(), rit());
    cyc(P_IDLE, 1'b1, rb(), rb(), rit());
  endtask

  task automatic check(input string name, input int cno, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cno, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("state", e.cyc_no, int'(State), int'(e.st));
        check("ctrl", e.cyc_no,
              int'({MemReq, IorD, IRWrite, PCEn, PCSrc, RegWrite, RegDst, MemtoReg,
                    ALUSrcA, ALUSrcB, ALUOp, Illegal}), int'(e.outs));
        check("count", e.cyc_no, int'(InstrCount), e.cnt);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset = 1'b1; Run = 1'b0; Zero = 1'b0; MemAck = 1'b0; InstrType = 4'd0;
    @(posedge clk);
    #1;
    cyc(P_IDLE, 1'b1, 1'b1, 1'b0, 4'd1);
    cyc(P_IDLE, 1'b1, 1'b0, 1'b0, 4'd1);
    reset = 1'b0;
    resume(1);

    do_instr(4'd1, 0, 0, 1'b0, 1'b1);   // R-type, ack tied high
    do_instr(4'd3, 0, 0, 1'b1, 1'b1);   // beq taken
    do_instr(4'd3, 0, 0, 1'b0, 1'b1);   // beq not taken
    do_instr(4'd4, 3, 2, 1'b0, 1'b1);   // lw with fetch/memory wait states
    do_instr(4'd0, 1, 0, 1'b0, 1'b1);   // unsupported -> Illegal, back to IF
    do_instr(4'd2, 0, 0, 1'b0, 1'b0);   // lui/ori with Run dropped -> IDLE
    resume(3);

    // Reset while MEM is waiting on MemAck: MemReq must drop immediately.
    for (int i = 0; i <= 1; i++) cyc(P_FETCH, 1'b1, (i == 1), 1'b0, 4'd0);
    cyc(P_DECODE, 1'b1, 1'b0, 1'b0, 4'd4);
    cyc(P_ADDR, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc(P_MEM, 1'b1, 1'b0, 1'b0, 4'd0);
    reset = 1'b1;
    exp_cnt = 0;
    cyc(P_IDLE, 1'b1, 1'b1, 1'b0, 4'd4);
    cyc(P_IDLE, 1'b1, 1'b0, 1'b0, 4'd4);
    reset = 1'b0;
    resume(0);

    for (int k = 0; k < 80; k++) begin
      logic [3:0] it;
      logic       run_end;
      it = (($urandom % 8) == 0) ? rit() : 4'($urandom % 5);
      run_end = (($urandom % 5) != 0);
      do_instr(it, int'($urandom % 4), int'($urandom % 4), rb(), run_end);
      if (!run_end) resume(int'($urandom % 3));
    end
    do_instr(4'd1, 0, 0, 1'b0, 1'b0);
    cyc(P_IDLE, 1'b0, 1'b1, 1'b0, 4'd0);

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drain", cyc_no, sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
